nn_image_avl_stream: RTL and testbench
======================================

# nn_image_avl_stream

Parametrised Avalon-MM slave between the HPS/Nios bus and the digit-recognition inference core. Software writes an image row-by-row into a register bank, then sets a start bit. The block streams the rows to the core over a valid/ready handshake, captures the core's classification result, and raises a maskable interrupt. It generalises the fixed 28×28×1-bit image interface with:
- configurable geometry and pixel depth,
- an explicit control/status/interrupt-clear protocol,
- back-pressured row streaming.

## Interface
Parameters:
- IMG_ROWS, 28, image rows; one 32-bit register per row; 1..60.
- IMG_COLS, 28, pixels per row.
- PIX_BITS, 1, bits per pixel; IMG_COLS*PIX_BITS ≤ 32.
- RESULT_W, 4, width of core result; ≤ 16.
- ADDR_W, 6, Avalon word-address width; 2^ADDR_W ≥ IMG_ROWS+3.

Ports (RW = IMG_COLS*PIX_BITS):
- CLK  in  1  single clock, all logic on rising edge.
- RESET  in  1  synchronous, active-high.
- AVL_CS  in  1  chip select.
- AVL_READ  in  1  read strobe.
- AVL_WRITE  in  1  write strobe.
- AVL_ADDR  in  ADDR_W  word address.
- AVL_WRITEDATA  in  32  write data.
- AVL_READDATA  out  32  read data; 2-cycle fixed latency.
- CHARACTER_IRQ  out  1  level interrupt = irq_pending & irq_en.
- ROW_VALID  out  1  row beat valid.
- ROW_READY  in  1  core accepts beat.
- ROW_DATA  out  RW  row pixels; bit RW-1 = leftmost pixel.
- ROW_IDX  out  6  row index of current beat.
- ROW_LAST  out  1  high on beat IMG_ROWS-1.
- RES_VALID  in  1  one-cycle result strobe from core.
- RES_DATA  in  RESULT_W  classification result.

## Operation
Address map (word addresses):
- 0..IMG_ROWS-1: ROW[n]. Bits [RW-1:0] are R/W; upper bits read 0.
- IMG_ROWS: RESULT. RO; [RESULT_W-1:0] = last captured result, zero-extended.
- IMG_ROWS+1: CTRL.
  - bit0 START: W1, self-clearing, reads 0.
  - bit1 IRQ_EN: R/W.
  - bit2 IRQ_CLR: W1C of irq_pending, reads 0.
- IMG_ROWS+2: STATUS. RO.
  - bit0 BUSY.
  - bit1 DONE: sticky until next START.
  - bit2 IRQ_PENDING.
  - bit3 WR_ERR: sticky, cleared by START.
- Other addresses: writes ignored; reads return 0.

A write occurs when AVL_CS & AVL_WRITE. A read occurs when AVL_CS & AVL_READ.

FSM states IDLE, STREAM, WAIT_RES:
- IDLE→STREAM on START=1. Actions on the START write:
  - row pointer cleared to 0.
  - DONE, WR_ERR and irq_pending cleared.
- STREAM: ROW_VALID=1, ROW_DATA=ROW[ptr], ROW_IDX=ptr, ROW_LAST=(ptr==IMG_ROWS-1).
  - On ROW_VALID & ROW_READY: ptr increments.
  - On the last beat: go to WAIT_RES.
  - ROW_DATA/ROW_IDX stay stable while ROW_READY=0.
- WAIT_RES: on RES_VALID, capture RES_DATA into RESULT, set DONE and irq_pending, go to IDLE.
- RES_VALID outside WAIT_RES is ignored.

Boundary rules:
- START while BUSY (state ≠ IDLE): ignored; no state change.
- ROW write while BUSY: dropped and WR_ERR set. Image stays coherent for the core.
- IRQ_CLR in the same cycle as RES_VALID capture: set wins, irq_pending=1.
- START+IRQ_CLR in one write from IDLE: start proceeds, irq_pending=0.
- Simultaneous AVL_READ and AVL_WRITE: write performed; read returns pre-write value.
- RESET at any time, including mid-stream:
  - state IDLE, all ROW, RESULT and IRQ_EN cleared to 0.
  - ptr=0, all flags 0.
  - the read pipeline is flushed.

## Timing
- Reset values: AVL_READDATA=0, CHARACTER_IRQ=0, ROW_VALID=0, ROW_DATA=0, ROW_IDX=0, ROW_LAST=0.
- Read latency: address sampled at edge T; data on AVL_READDATA after edge T+2, held until the next read result. There is no waitrequest, so back-to-back reads pipeline at 1 per cycle.
- Write takes effect at the sampling edge. A read issued the cycle after a write returns the new value.
- START write at edge T: BUSY=1 and ROW_VALID=1 after T.
- With ROW_READY held 1, the stream takes exactly IMG_ROWS cycles: ROW_VALID drops after the beat-IMG_ROWS-1 edge.
- RES_VALID at edge T: RESULT, DONE and IRQ_PENDING update after T, BUSY=0 after T, and CHARACTER_IRQ rises after T if IRQ_EN=1.
- All outputs registered except CHARACTER_IRQ, which is the AND of two registers.

## Test plan
- Defaults, after RESET: write ROW[0..27] = 0x0000001+n, then read them back → each returns the written value after exactly 2 cycles, bits [31:28]=0. Read of address 31 → 0.
- Stream with ROW_READY=1 after START (CTRL=0x3): 28 beats in 28 cycles, ROW_IDX 0..27, ROW_LAST only on IDX 27. Then drive RES_VALID with RES_DATA=7 → RESULT reads 0x7, STATUS=0x6, CHARACTER_IRQ=1.
- Back-pressure: ROW_READY toggles 1-0-0-1 → ROW_DATA/ROW_IDX stable while stalled; beat count = 28, no row skipped or duplicated.
- BUSY protections: write ROW[3] and START during STREAM → ROW[3] unchanged, stream continues, STATUS.WR_ERR=1 until the next START.
- IRQ handling:
  - IRQ_CLR (CTRL=0x6) → CHARACTER_IRQ=0 next cycle, IRQ_PENDING=0.
  - IRQ_CLR coincident with RES_VALID → IRQ_PENDING=1.
  - IRQ_EN=0 → pending set but CHARACTER_IRQ stays 0.
- RESET mid-stream at beat 10 → all outputs at reset values next cycle; ROW registers read 0. A new START streams zeros.
- Geometry: separate build with IMG_ROWS=16, IMG_COLS=8, PIX_BITS=4 → 16 beats of 32-bit rows; RESULT at address 16, CTRL at 17, STATUS at 18.

Source files
------------

// File: rtl/nn_image_avl_stream.sv
// Avalon-MM image register bank that streams rows to the digit-recognition core
// over valid/ready, captures the classification result and raises a maskable IRQ.
module nn_image_avl_stream #(
    parameter int IMG_ROWS = 28,
    parameter int IMG_COLS = 28,
    parameter int PIX_BITS = 1,
    parameter int RESULT_W = 4,
    parameter int ADDR_W   = 6
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic                         AVL_CS,
    input  logic                         AVL_READ,
    input  logic                         AVL_WRITE,
    input  logic [ADDR_W-1:0]            AVL_ADDR,
    input  logic [31:0]                  AVL_WRITEDATA,
    output logic [31:0]                  AVL_READDATA,
    output logic                         CHARACTER_IRQ,
    output logic                         ROW_VALID,
    input  logic                         ROW_READY,
    output logic [IMG_COLS*PIX_BITS-1:0] ROW_DATA,
    output logic [5:0]                   ROW_IDX,
    output logic                         ROW_LAST,
    input  logic                         RES_VALID,
    input  logic [RESULT_W-1:0]          RES_DATA
);
    // state      | meaning
    // S_IDLE     | waiting for START, image registers writable
    // S_STREAM   | presenting ROW[ptr] to the core, advancing on each accepted beat
    // S_WAIT_RES | all rows sent, waiting for the core's result strobe

    localparam int RW = IMG_COLS * PIX_BITS;
    localparam logic [ADDR_W-1:0] A_RESULT = ADDR_W'(IMG_ROWS);
    localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(IMG_ROWS + 1);
    localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(IMG_ROWS + 2);
    localparam logic [5:0]        LAST_PTR = 6'(IMG_ROWS - 1);

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_WAIT_RES} state_t;

    state_t              state_q, state_d;
    logic [RW-1:0]       row_q [IMG_ROWS];
    logic [RW-1:0]       row_d [IMG_ROWS];
    logic [RESULT_W-1:0] result_q, result_d;
    logic                irq_en_q, irq_en_d;
    logic                done_q, done_d;
    logic                pend_q, pend_d;
    logic                wr_err_q, wr_err_d;
    logic [5:0]          ptr_q, ptr_d;

    logic                row_valid_q, row_valid_d;
    logic [RW-1:0]       row_data_q, row_data_d;
    logic [5:0]          row_idx_q, row_idx_d;
    logic                row_last_q, row_last_d;

    logic                rd1_vld_q, rd1_vld_d;
    logic                rd2_vld_q, rd2_vld_d;
    logic [31:0]         rd1_q, rd1_d;
    logic [31:0]         rd2_q, rd2_d;
    logic [31:0]         readdata_q, readdata_d;

    logic                wr_en, rd_en, busy, ctrl_wr, row_wr_hit;
    logic                start_go, beat, last_beat, capture;
    logic [RW-1:0]       row_sel;
    logic [31:0]         rd_mux;
    logic                unused_wdata;

    assign wr_en      = AVL_CS & AVL_WRITE;
    assign rd_en      = AVL_CS & AVL_READ;
    assign busy       = (state_q != S_IDLE);
    assign ctrl_wr    = wr_en && (AVL_ADDR == A_CTRL);
    assign row_wr_hit = wr_en && (AVL_ADDR < A_RESULT);
    assign start_go   = ctrl_wr && AVL_WRITEDATA[0] && !busy;
    assign beat       = (state_q == S_STREAM) && ROW_READY;
    assign last_beat  = beat && (ptr_q == LAST_PTR);
    assign capture    = (state_q == S_WAIT_RES) && RES_VALID;
    assign unused_wdata = ^AVL_WRITEDATA;

    // FSM: state register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (start_go)  state_d = S_STREAM;
            S_STREAM:   if (last_beat) state_d = S_WAIT_RES;
            S_WAIT_RES: if (RES_VALID) state_d = S_IDLE;
            default:                   state_d = S_IDLE;
        endcase
    end

    // FSM: stream outputs, precomputed from the next state so the ports are registered
    always_comb begin
        row_sel = '0;
        for (int i = 0; i < IMG_ROWS; i++) begin
            if (ptr_d == 6'(i)) row_sel = row_q[i];
        end
        row_valid_d = (state_d == S_STREAM);
        row_data_d  = row_valid_d ? row_sel : '0;
        row_idx_d   = row_valid_d ? ptr_d : 6'd0;
        row_last_d  = row_valid_d && (ptr_d == LAST_PTR);
    end

    always_comb begin
        row_d    = row_q;
        result_d = result_q;
        irq_en_d = irq_en_q;
        done_d   = done_q;
        pend_d   = pend_q;
        wr_err_d = wr_err_q;
        ptr_d    = ptr_q;

        // Rows are frozen while busy so the core always sees a coherent image
        if (row_wr_hit && busy) wr_err_d = 1'b1;
        for (int i = 0; i < IMG_ROWS; i++) begin
            if (row_wr_hit && !busy && (AVL_ADDR == ADDR_W'(i))) begin
                row_d[i] = AVL_WRITEDATA[RW-1:0];
            end
        end

        if (ctrl_wr) begin
            irq_en_d = AVL_WRITEDATA[1];
            if (AVL_WRITEDATA[2]) pend_d = 1'b0;
        end
        if (start_go) begin
            ptr_d    = 6'd0;
            done_d   = 1'b0;
            wr_err_d = 1'b0;
            pend_d   = 1'b0;
        end
        if (beat) ptr_d = ptr_q + 6'd1;

        // A result capture outranks a coincident interrupt clear
        if (capture) begin
            result_d = RES_DATA;
            done_d   = 1'b1;
            pend_d   = 1'b1;
        end
    end

    // Read data is captured at the address edge, so a simultaneous write is not visible
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < IMG_ROWS; i++) begin
            if (AVL_ADDR == ADDR_W'(i)) rd_mux[RW-1:0] = row_q[i];
        end
        if (AVL_ADDR == A_RESULT) rd_mux[RESULT_W-1:0] = result_q;
        if (AVL_ADDR == A_CTRL)   rd_mux[1] = irq_en_q;
        if (AVL_ADDR == A_STATUS) rd_mux[3:0] = {wr_err_q, pend_q, done_q, busy};

        rd1_vld_d  = rd_en;
        rd1_d      = rd_mux;
        rd2_vld_d  = rd1_vld_q;
        rd2_d      = rd1_q;
        readdata_d = rd2_vld_q ? rd2_q : readdata_q;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < IMG_ROWS; i++) row_q[i] <= '0;
            result_q    <= '0;
            irq_en_q    <= 1'b0;
            done_q      <= 1'b0;
            pend_q      <= 1'b0;
            wr_err_q    <= 1'b0;
            ptr_q       <= 6'd0;
            row_valid_q <= 1'b0;
            row_data_q  <= '0;
            row_idx_q   <= 6'd0;
            row_last_q  <= 1'b0;
            rd1_vld_q   <= 1'b0;
            rd2_vld_q   <= 1'b0;
            rd1_q       <= '0;
            rd2_q       <= '0;
            readdata_q  <= '0;
        end else begin
            row_q       <= row_d;
            result_q    <= result_d;
            irq_en_q    <= irq_en_d;
            done_q      <= done_d;
            pend_q      <= pend_d;
            wr_err_q    <= wr_err_d;
            ptr_q       <= ptr_d;
            row_valid_q <= row_valid_d;
            row_data_q  <= row_data_d;
            row_idx_q   <= row_idx_d;
            row_last_q  <= row_last_d;
            rd1_vld_q   <= rd1_vld_d;
            rd2_vld_q   <= rd2_vld_d;
            rd1_q       <= rd1_d;
            rd2_q       <= rd2_d;
            readdata_q  <= readdata_d;
        end
    end

    assign AVL_READDATA  = readdata_q;
    assign CHARACTER_IRQ = pend_q & irq_en_q;
    assign ROW_VALID     = row_valid_q;
    assign ROW_DATA      = row_data_q;
    assign ROW_IDX       = row_idx_q;
    assign ROW_LAST      = row_last_q;

endmodule

// File: tb/tb_nn_image_avl_stream.sv
// Scoreboard bench for nn_image_avl_stream: default 28x28x1 build plus a 16x8x4 geometry build.
module tb_nn_image_avl_stream;
    localparam logic [5:0] A_RESULT = 6'd28;
    localparam logic [5:0] A_CTRL   = 6'd29;
    localparam logic [5:0] A_STATUS = 6'd30;

    logic        clk = 1'b0;
    logic        rst, cs, rd, wr, rready, res_v;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  res_d;
    wire  [31:0] rdata;
    wire         irq, rvalid, rlast;
    wire  [27:0] rdat;
    wire  [5:0]  ridx;

    logic        g_rst, g_cs, g_rd, g_wr, g_rready, g_res_v;
    logic [4:0]  g_addr;
    logic [31:0] g_wdata;
    logic [3:0]  g_res_d;
    wire  [31:0] g_rdata, g_rdat;
    wire         g_irq, g_rvalid, g_rlast;
    wire  [5:0]  g_ridx;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [27:0] exp_row [28];
    logic [31:0] g_exp [16];
    logic [31:0] exp_q [$];
    logic [31:0] beat_q [$];

    always #5 clk = ~clk;

    nn_image_avl_stream u_dut (
        .CLK(clk), .RESET(rst), .AVL_CS(cs), .AVL_READ(rd), .AVL_WRITE(wr),
        .AVL_ADDR(addr), .AVL_WRITEDATA(wdata), .AVL_READDATA(rdata),
        .CHARACTER_IRQ(irq), .ROW_VALID(rvalid), .ROW_READY(rready),
        .ROW_DATA(rdat), .ROW_IDX(ridx), .ROW_LAST(rlast),
        .RES_VALID(res_v), .RES_DATA(res_d)
    );

    nn_image_avl_stream #(.IMG_ROWS(16), .IMG_COLS(8), .PIX_BITS(4), .RESULT_W(4), .ADDR_W(5)) u_geo (
        .CLK(clk), .RESET(g_rst), .AVL_CS(g_cs), .AVL_READ(g_rd), .AVL_WRITE(g_wr),
        .AVL_ADDR(g_addr), .AVL_WRITEDATA(g_wdata), .AVL_READDATA(g_rdata),
        .CHARACTER_IRQ(g_irq), .ROW_VALID(g_rvalid), .ROW_READY(g_rready),
        .ROW_DATA(g_rdat), .ROW_IDX(g_ridx), .ROW_LAST(g_rlast),
        .RES_VALID(g_res_v), .RES_DATA(g_res_d)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic avl_wr(input logic [5:0] a, input logic [31:0] d);
        cs = 1'b1; wr = 1'b1; addr = a; wdata = d;
        cyc();
        cs = 1'b0; wr = 1'b0;
    endtask

    task automatic avl_rd(input logic [5:0] a, output logic [31:0] d);
        cs = 1'b1; rd = 1'b1; addr = a;
        cyc();
        cs = 1'b0; rd = 1'b0;
        cyc();
        cyc();
        d = rdata;
    endtask

    task automatic g_avl_wr(input logic [4:0] a, input logic [31:0] d);
        g_cs = 1'b1; g_wr = 1'b1; g_addr = a; g_wdata = d;
        cyc();
        g_cs = 1'b0; g_wr = 1'b0;
    endtask

    task automatic g_avl_rd(input logic [4:0] a, output logic [31:0] d);
        g_cs = 1'b1; g_rd = 1'b1; g_addr = a;
        cyc();
        g_cs = 1'b0; g_rd = 1'b0;
        cyc();
        cyc();
        d = g_rdata;
    endtask

    task automatic drain();
        rready = 1'b1;
        for (int i = 0; i < 200 && rvalid; i++) cyc();
        n_cmp++;
        if (rvalid !== 1'b0) begin
            n_err++;
            $display("FAIL drain_timeout: row_valid=%b required 0", rvalid);
        end
    endtask

    task automatic finish_job(input logic [3:0] r);
        drain();
        res_d = r; res_v = 1'b1;
        cyc();
        res_v = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] got, e;
        rst = 1'b1; g_rst = 1'b1;
        cyc(); cyc();
        rst = 1'b0; g_rst = 1'b0;
        n_cmp++;
        if ({rdata, irq, rvalid, rdat, ridx, rlast} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: rdata=%h irq=%b valid=%b data=%h idx=%0d last=%b required all 0",
                     rdata, irq, rvalid, rdat, ridx, rlast);
        end
        exp_q.push_back(32'h0);
        avl_rd(A_STATUS, got);
        e = exp_q.pop_front();
        n_cmp++;
        if (got !== e) begin n_err++; $display("FAIL reset_status: got %h required %h", got, e); end
    endtask

    task automatic test_rows();
        logic [31:0] got, e;
        for (int n = 0; n < 28; n++) begin
            avl_wr(6'(n), 32'hF000_0001 + 32'(n));
            exp_row[n] = 28'(32'h1 + 32'(n));
        end
        // Pipelined reads: one per cycle, each result must appear exactly two edges later
        for (int k = 0; k < 30; k++) begin
            if (k < 28) begin
                cs = 1'b1; rd = 1'b1; addr = 6'(k);
                exp_q.push_back(32'(exp_row[k]));
            end else begin
                cs = 1'b0; rd = 1'b0;
            end
            cyc();
            if (k >= 2) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (rdata !== e) begin
                    n_err++;
                    $display("FAIL row_readback[%0d]: got %h required %h", k - 2, rdata, e);
                end
            end
        end
        cyc();
        n_cmp++;
        if (rdata !== 32'(exp_row[27])) begin
            n_err++;
            $display("FAIL readdata_hold: got %h required %h", rdata, 32'(exp_row[27]));
        end
        avl_wr(6'd31, 32'hDEAD_BEEF);
        exp_q.push_back(32'h0);
        avl_rd(6'd31, got);
        e = exp_q.pop_front();
        n_cmp++;
        if (got !== e) begin n_err++; $display("FAIL unmapped_read: got %h required %h", got, e); end
    endtask

    task automatic test_stream();
        logic [31:0] got, e;
        rready = 1'b1;
        for (int n = 0; n < 28; n++) beat_q.push_back(32'(exp_row[n]));
        avl_wr(A_CTRL, 32'h3);
        for (int b = 0; b < 28; b++) begin
            e = beat_q.pop_front();
            n_cmp++;
            if ({rvalid, ridx, rdat, rlast} !== {1'b1, 6'(b), e[27:0], (b == 27)}) begin
                n_err++;
                $display("FAIL stream_beat[%0d]: valid=%b idx=%0d data=%h last=%b required 1/%0d/%h/%b",
                         b, rvalid, ridx, rdat, rlast, b, e[27:0], (b == 27));
            end
            cyc();
        end
        n_cmp++;
        if (rvalid !== 1'b0) begin n_err++; $display("FAIL stream_end: row_valid=%b required 0", rvalid); end
        exp_q.push_back(32'h1);
        avl_rd(A_STATUS, got);
        e = exp_q.pop_front();
        n_cmp++;
        if (got !== e) begin n_err++; $display("FAIL wait_status: got %h required %h", got, e); end
        res_d = 4'd7; res_v = 1'b1;
        cyc();
        res_v = 1'b0;
        n_cmp++;
        if (irq !== 1'b1) begin n_err++; $display("FAIL result_irq: irq=%b required 1", irq); end
        // Strobes outside WAIT_RES must not disturb the captured result
        res_d = 4'd5; res_v = 1'b1;
        cyc();
        res_v = 1'b0;
        exp_q.push_back(32'h7);
        avl_rd(A_RESULT, got);
        e = exp_q.pop_front();
        n_cmp++;
        if (got !== e) begin n_err++; $display("FAIL result_reg: got %h required %h", got, e); end
        exp_q.push_back(32'h6);
        avl_rd(A_STATUS, got);
        e = exp_q.pop_front();
        n_cmp++;
        if (got !== e) begin n_err++; $display("FAIL done_status: got %h required %h", got, e); end
    endtask

    task automatic test_backpressure();
        int          pat [4] = '{1, 0, 0, 1};
        int          beats = 0;
        logic [31:0] e;
        rready = 1'b0;
        for (int n = 0; n < 28; n++) beat_q.push_back(32'(exp_row[n]));
        avl_wr(A_CTRL, 32'h3);
        for (int c = 0; c < 200 && beats < 28; c++) begin
            rready = pat[c % 4][0];
            e = beat_q[0];
            n_cmp++;
            if ({rvalid, ridx, rdat} !== {1'b1, 6'(beats), e[27:0]}) begin
                n_err++;
                $display("FAIL bp_beat[%0d]: valid=%b idx=%0d data=%h required 1/%0d/%h",
                         beats, rvalid, ridx, rdat, beats, e[27:0]);
            end
            if (rready) begin
                void'(beat_q.pop_front());
                beats++;
            end
            cyc();
        end
        n_cmp++;
        if ({beats, rvalid} !== {32'd28, 1'b0}) begin
            n_err++;
            $display("FAIL bp_count: beats=%0d valid=%b required 28/0", beats, rvalid);
        end
        beat_q.delete();
        finish_job(4'd3);
    endtask

    task automatic test_busy();
        logic [31:0] got, e;
        rready = 1'b1;
        avl_wr(A_CTRL, 32'h3);
        cyc();
        rready = 1'b0;
        avl_wr(6'd3, 32'h0ABC_DEF0);
        avl_wr(A_CTRL, 32'h3);
        n_cmp++;
        if ({ridx, rdat} !== {6'd1, exp_row[1]}) begin
            n_err++;
            $display("FAIL busy_no_restart: idx=%0d data=%h required 1/%h", ridx, rdat, exp_row[1]);
        end
        exp_q.push_back(32'h9);
        avl_rd(A_STATUS, got);
        e = exp_q.pop_front();
        n_cmp++;
        if (got !== e) begin n_err++; $display("FAIL busy_status: got %h required %h", got, e); end
        rready = 1'b1;
        for (int b = 1; b < 28; b++) begin
            n_cmp++;
            if ({rvalid, ridx, rdat} !== {1'b1, 6'(b), exp_row[b]}) begin
                n_err++;
                $display("FAIL busy_beat[%0d]: valid=%b idx=%0d data=%h required 1/%0d/%h",
                         b, rvalid, ridx, rdat, b, exp_row[b]);
            end
            cyc();
        end
        finish_job(4'd1);
        exp_q.push_back(32'hE);
        avl_rd(A_STATUS, got);
        e = exp_q.pop_front();
        n_cmp++;
        if (got !== e) begin n_err++; $display("FAIL wr_err_sticky: got %h required %h", got, e); end
        exp_q.push_back(32'(exp_row[3]));
        avl_rd(6'd3, got);
        e = exp_q.pop_front();
        n_cmp++;
        if (got !== e) begin n_err++; $display("FAIL row3_kept: got %h required %h", got, e); end
        avl_wr(A_CTRL, 32'h3);
        exp_q.push_back(32'h1);
        avl_rd(A_STATUS, got);
        e = exp_q.pop_front();
        n_cmp++;
        if (got !== e) begin n_err++; $display("FAIL wr_err_clear: got %h required %h", got, e); end
        finish_job(4'd2);
    endtask

    task automatic test_irq();
        logic [31:0] got, e;
        n_cmp++;
        if (irq !== 1'b1) begin n_err++; $display("FAIL irq_before_clr: irq=%b required 1", irq); end
        avl_wr(A_CTRL, 32'h6);
        n_cmp++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL irq_clr: irq=%b required 0", irq); end
        exp_q.push_back(32'h2);
        avl_rd(A_STATUS, got);
        e = exp_q.pop_front();
        n_cmp++;
        if (got !== e) begin n_err++; $display("FAIL clr_status: got %h required %h", got, e); end
        exp_q.push_back(32'h2);
        avl_rd(A_CTRL, got);
        e = exp_q.pop_front();
        n_cmp++;
        if (got !== e) begin n_err++; $display("FAIL ctrl_read: got %h required %h", got, e); end

        avl_wr(A_CTRL, 32'h3);
        drain();
        cs = 1'b1; wr = 1'b1; addr = A_CTRL; wdata = 32'h6;
        res_d = 4'd9; res_v = 1'b1;
        cyc();
        cs = 1'b0; wr = 1'b0; res_v = 1'b0;
        n_cmp++;
        if (irq !== 1'b1) begin n_err++; $display("FAIL clr_vs_set_irq: irq=%b required 1", irq); end
        exp_q.push_back(32'h6);
        avl_rd(A_STATUS, got);
        e = exp_q.pop_front();
        n_cmp++;
        if (got !== e) begin n_err++; $display("FAIL clr_vs_set_status: got %h required %h", got, e); end

        avl_wr(A_CTRL, 32'h7);
        n_cmp++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL start_clr_irq: irq=%b required 0", irq); end
        exp_q.push_back(32'h1);
        avl_rd(A_STATUS, got);
        e = exp_q.pop_front();
        n_cmp++;
        if (got !== e) begin n_err++; $display("FAIL start_clr_status: got %h required %h", got, e); end
        finish_job(4'd4);

        avl_wr(A_CTRL, 32'h5);
        finish_job(4'd2);
        n_cmp++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL masked_irq: irq=%b required 0", irq); end
        exp_q.push_back(32'h6);
        avl_rd(A_STATUS, got);
        e = exp_q.pop_front();
        n_cmp++;
        if (got !== e) begin n_err++; $display("FAIL masked_status: got %h required %h", got, e); end
        exp_q.push_back(32'h2);
        avl_rd(A_RESULT, got);
        e = exp_q.pop_front();
        n_cmp++;
        if (got !== e) begin n_err++; $display("FAIL masked_result: got %h required %h", got, e); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] got, e;
        logic [5:0]  chk_addr [4] = '{6'd0, 6'd27, A_RESULT, A_CTRL};
        rready = 1'b1;
        avl_wr(A_CTRL, 32'h3);
        for (int i = 0; i < 10; i++) cyc();
        n_cmp++;
        if (ridx !== 6'd10) begin n_err++; $display("FAIL mid_beat_idx: idx=%0d required 10", ridx); end
        cs = 1'b1; rd = 1'b1; addr = 6'd5;
        cyc();
        cs = 1'b0; rd = 1'b0; rst = 1'b1;
        cyc();
        rst = 1'b0;
        for (int n = 0; n < 28; n++) exp_row[n] = '0;
        n_cmp++;
        if ({rdata, irq, rvalid, rdat, ridx, rlast} !== '0) begin
            n_err++;
            $display("FAIL midreset_outputs: rdata=%h irq=%b valid=%b data=%h idx=%0d last=%b required all 0",
                     rdata, irq, rvalid, rdat, ridx, rlast);
        end
        cyc();
        cyc();
        n_cmp++;
        if (rdata !== 32'h0) begin n_err++; $display("FAIL read_flush: got %h required 0", rdata); end
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(32'h0);
            avl_rd(chk_addr[i], got);
            e = exp_q.pop_front();
            n_cmp++;
            if (got !== e) begin
                n_err++;
                $display("FAIL midreset_reg[%0d]: got %h required %h", chk_addr[i], got, e);
            end
        end
        for (int n = 0; n < 28; n++) beat_q.push_back(32'(exp_row[n]));
        avl_wr(A_CTRL, 32'h1);
        for (int b = 0; b < 28; b++) begin
            e = beat_q.pop_front();
            n_cmp++;
            if ({rvalid, ridx, rdat} !== {1'b1, 6'(b), e[27:0]}) begin
                n_err++;
                $display("FAIL zero_beat[%0d]: valid=%b idx=%0d data=%h required 1/%0d/%h",
                         b, rvalid, ridx, rdat, b, e[27:0]);
            end
            cyc();
        end
        finish_job(4'd0);
    endtask

    task automatic test_geometry();
        logic [31:0] got, e;
        for (int n = 0; n < 16; n++) begin
            g_exp[n] = 32'h8000_0001 + 32'(n) * 32'h0101_0101;
            g_avl_wr(5'(n), g_exp[n]);
        end
        exp_q.push_back(g_exp[15]);
        g_avl_rd(5'd15, got);
        e = exp_q.pop_front();
        n_cmp++;
        if (got !== e) begin n_err++; $display("FAIL geo_row15: got %h required %h", got, e); end
        g_rready = 1'b1;
        for (int n = 0; n < 16; n++) beat_q.push_back(g_exp[n]);
        g_avl_wr(5'd17, 32'h3);
        for (int b = 0; b < 16; b++) begin
            e = beat_q.pop_front();
            n_cmp++;
            if ({g_rvalid, g_ridx, g_rdat, g_rlast} !== {1'b1, 6'(b), e, (b == 15)}) begin
                n_err++;
                $display("FAIL geo_beat[%0d]: valid=%b idx=%0d data=%h last=%b required 1/%0d/%h/%b",
                         b, g_rvalid, g_ridx, g_rdat, g_rlast, b, e, (b == 15));
            end
            cyc();
        end
        n_cmp++;
        if (g_rvalid !== 1'b0) begin n_err++; $display("FAIL geo_end: row_valid=%b required 0", g_rvalid); end
        g_res_d = 4'hB; g_res_v = 1'b1;
        cyc();
        g_res_v = 1'b0;
        n_cmp++;
        if (g_irq !== 1'b1) begin n_err++; $display("FAIL geo_irq: irq=%b required 1", g_irq); end
        exp_q.push_back(32'hB);
        g_avl_rd(5'd16, got);
        e = exp_q.pop_front();
        n_cmp++;
        if (got !== e) begin n_err++; $display("FAIL geo_result: got %h required %h", got, e); end
        exp_q.push_back(32'h6);
        g_avl_rd(5'd18, got);
        e = exp_q.pop_front();
        n_cmp++;
        if (got !== e) begin n_err++; $display("FAIL geo_status: got %h required %h", got, e); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
        rready = 1'b0; res_v = 1'b0; res_d = '0;
        g_rst = 1'b1; g_cs = 1'b0; g_rd = 1'b0; g_wr = 1'b0; g_addr = '0; g_wdata = '0;
        g_rready = 1'b0; g_res_v = 1'b0; g_res_d = '0;
        test_reset();
        test_rows();
        test_stream();
        test_backpressure();
        test_busy();
        test_irq();
        test_reset_mid();
        test_geometry();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
